// File: rtl/mm1_dmem_if_pkg.sv
// mm1_dmem_if_pkg
//   Shared definitions for the MM1 data-memory front end:
//   - access-size encodings carried on mm1_access_sz / data_size
//   - FSM state encoding of the single-outstanding bus sequencer
//   - alignment helper used to decide whether an access may be issued
package mm1_dmem_if_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;  // 2'd3 is reserved and behaves as a word

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // may issue the held MM1 access
    ST_WAIT   = 2'd1,  // request accepted, waiting for data_ok
    ST_DONE   = 2'd2,  // access complete, waiting for MM2 to take it
    ST_CANCEL = 2'd3   // owner was flushed, draining its response
  } state_t;

  // Half needs addr[0]=0, word (and reserved size) needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mm1_dmem_if_if.sv
// mm1_dmem_if_if
//   SRAM-like data bus between the MM1 front end and data memory.
//   Request phase : data_req / data_wr / data_size / data_addr / data_wstrb / data_wdata,
//                   accepted by data_addr_ok.
//   Response phase: data_data_ok with data_rdata (loads) or write completion (stores).
//   modport master: the front end (drives the request).
//   modport slave : the memory (drives addr_ok, data_ok, rdata).
interface mm1_dmem_if_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mm1_ld_align.sv
// mm1_ld_align
//   Purely combinational byte-lane logic for the MM1 data access.
//   Inputs : access_sz, addr_lo (addr[1:0]), is_store, ld_unsigned, wdata (LSB-aligned),
//            rdata (raw bus word)
//   Outputs: wstrb (byte strobes, zero for loads), wdata_rep (store data replicated
//            across lanes), ld_result (selected, zero/sign-extended load value)
module mm1_ld_align
  import mm1_dmem_if_pkg::*;
(
  input  logic [1:0]  access_sz,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic        ld_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_result
);

  // Only the low 16 bits of the lane-shifted word are ever needed.
  logic [15:0] sh;

  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    ld_result = rdata;
    sh        = 16'(rdata >> {addr_lo, 3'b000});

    case (access_sz)
      SZ_B: begin
        if (is_store) wstrb = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        ld_result = {{24{~ld_unsigned & sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        if (is_store) wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        ld_result = {{16{~ld_unsigned & sh[15]}}, sh[15:0]};
      end
      default: begin
        if (is_store) wstrb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mm1_dmem_if.sv
// mm1_dmem_if
//   MM1-stage data-memory front end. Turns the access held in the EX/MM1 register
//   into one transaction on the SRAM-like bus, stalls EX/MM1 until it completes,
//   registers the aligned load result for MM2, and drains responses whose owning
//   instruction was flushed.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     mm1_*               held MM1 access (valid, re, we, size, addr, wdata, unsigned, excp)
//     flush               pipeline flush (same as the EX/MM1 register's flush)
//     mm2_ready           MM1/MM2 register accepts this cycle
//     dbus                data bus, master side
//     mm1_stall           hold EX/MM1 and upstream
//     ld_valid, ld_data   registered load result for the MM1/MM2 register
module mm1_dmem_if
  import mm1_dmem_if_pkg::*;
#(
  parameter bit ALE_SUPPRESS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mm1_valid,
  input  logic                  mm1_re,
  input  logic                  mm1_we,
  input  logic [1:0]            mm1_access_sz,
  input  logic [31:0]           mm1_addr,
  input  logic [31:0]           mm1_wdata,
  input  logic                  mm1_ld_unsigned,
  input  logic                  mm1_excp,
  input  logic                  flush,
  input  logic                  mm2_ready,
  mm1_dmem_if_if.master         dbus,
  output logic                  mm1_stall,
  output logic                  ld_valid,
  output logic [31:0]           ld_data
);

  state_t      state_reg, state_next;
  logic        ld_valid_reg, ld_valid_next;
  logic [31:0] ld_data_reg, ld_data_next;

  logic        mem_op;
  logic        misaligned;
  logic        access_en;
  logic        req;
  logic        stall;
  logic [3:0]  wstrb;
  logic [31:0] wdata_rep;
  logic [31:0] ld_result;

  assign mem_op     = mm1_valid & (mm1_re | mm1_we);
  assign misaligned = is_misaligned(mm1_access_sz, mm1_addr[1:0]);
  assign access_en  = mem_op & ~mm1_excp & ~flush & ~(ALE_SUPPRESS & misaligned);

  mm1_ld_align u_align (
    .access_sz   (mm1_access_sz),
    .addr_lo     (mm1_addr[1:0]),
    .is_store    (mm1_we),
    .ld_unsigned (mm1_ld_unsigned),
    .wdata       (mm1_wdata),
    .rdata       (dbus.data_rdata),
    .wstrb       (wstrb),
    .wdata_rep   (wdata_rep),
    .ld_result   (ld_result)
  );

  // Request fields come straight from the held MM1 access; the stall keeps
  // them stable until addr_ok.
  assign dbus.data_req    = req;
  assign dbus.data_wr     = mm1_we;
  assign dbus.data_size   = mm1_access_sz;
  assign dbus.data_addr   = mm1_addr;
  assign dbus.data_wstrb  = wstrb;
  assign dbus.data_wdata  = wdata_rep;

  assign mm1_stall = stall;
  assign ld_valid  = ld_valid_reg;
  assign ld_data   = ld_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      ld_valid_reg <= 1'b0;
      ld_data_reg  <= 32'h0;
    end else begin
      state_reg    <= state_next;
      ld_valid_reg <= ld_valid_next;
      ld_data_reg  <= ld_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ld_valid_next = ld_valid_reg;
    ld_data_next  = ld_data_reg;
    req           = 1'b0;
    stall         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        req   = access_en;
        stall = access_en;
        if (access_en & dbus.data_addr_ok) state_next = ST_WAIT;
      end

      ST_WAIT: begin
        stall = 1'b1;
        if (dbus.data_data_ok) begin
          if (flush) begin
            // Response belongs to the instruction being flushed: drop it.
            state_next = ST_IDLE;
          end else begin
            if (!mm1_we) begin
              ld_data_next  = ld_result;
              ld_valid_next = 1'b1;
            end
            state_next = ST_DONE;
          end
        end else if (flush) begin
          state_next = ST_CANCEL;
        end
      end

      ST_DONE: begin
        stall = ~mm2_ready;
        if (mm2_ready | flush) begin
          ld_valid_next = 1'b0;
          state_next    = ST_IDLE;
        end
      end

      ST_CANCEL: begin
        // A fresh access may already be held; it waits here without issuing
        // because the bus still owes the flushed instruction a response.
        stall = mem_op;
        if (dbus.data_data_ok) state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mm1_dmem_if.sv
// tb_mm1_dmem_if
//   Drives a stream of MM1 accesses (directed cases first, then random) against a
//   behavioural memory with random addr_ok/data_ok timing and occasional flushes.
//   Expected bus requests and load results are queued as instructions are issued;
//   a separate monitor pops and compares them whenever the DUT presents a request
//   acceptance or a consumed load result.
module tb_mm1_dmem_if;
  import mm1_dmem_if_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mm1_valid, mm1_re, mm1_we, mm1_ld_unsigned, mm1_excp;
  logic [1:0]  mm1_access_sz;
  logic [31:0] mm1_addr, mm1_wdata;
  logic        flush, mm2_ready;
  logic        mm1_stall, ld_valid;
  logic [31:0] ld_data;

  mm1_dmem_if_if dbus();

  mm1_dmem_if #(.ALE_SUPPRESS(1'b1)) dut (
    .clk             (clk),
    .rst             (rst),
    .mm1_valid       (mm1_valid),
    .mm1_re          (mm1_re),
    .mm1_we          (mm1_we),
    .mm1_access_sz   (mm1_access_sz),
    .mm1_addr        (mm1_addr),
    .mm1_wdata       (mm1_wdata),
    .mm1_ld_unsigned (mm1_ld_unsigned),
    .mm1_excp        (mm1_excp),
    .flush           (flush),
    .mm2_ready       (mm2_ready),
    .dbus            (dbus),
    .mm1_stall       (mm1_stall),
    .ld_valid        (ld_valid),
    .ld_data         (ld_data)
  );

  typedef struct {
    logic        valid, re, we, excp, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wdata, rdata;
    int          aok;    // cycles of addr_ok low after presentation
    int          dok;    // extra cycles after acceptance before data_ok
    int          fmode;  // 0 none, 1 flush while waiting, 2 flush with data_ok
    logic        has_exp;
    logic [31:0] exp_ld;
  } instr_t;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  instr_t      prog[$];
  req_t        req_q[$];
  logic [31:0] ld_q[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-lane arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit mem_op(input instr_t i);
    return i.valid && (i.re || i.we);
  endfunction

  function automatic bit eligible(input instr_t i);
    bit aligned = (int'(i.addr[1:0]) % nbytes(i.sz)) == 0;
    return mem_op(i) && !i.excp && aligned;
  endfunction

  function automatic req_t model_req(input instr_t i);
    req_t r;
    int   n   = nbytes(i.sz);
    int   off = int'(i.addr[1:0]);
    r.wr    = i.we;
    r.sz    = i.sz;
    r.addr  = i.addr;
    r.wstrb = 4'b0000;
    r.wdata = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (i.we && b >= off && b < off + n) r.wstrb[b] = 1'b1;
      r.wdata[8*b +: 8] = i.wdata[8*(b % n) +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_ld(input instr_t i, input logic [31:0] rd);
    logic [31:0] v   = 32'h0;
    int          n   = nbytes(i.sz);
    int          off = int'(i.addr[1:0]);
    for (int k = 0; k < n; k++) v[8*k +: 8] = rd[8*(off+k) +: 8];
    if (!i.uns && n < 4 && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic instr_t mk(input bit re, input bit we, input logic [1:0] sz,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input bit uns, input bit excp,
                                input int aok, input int dok, input int fmode,
                                input bit has_exp, input logic [31:0] exp_ld);
    instr_t t;
    t.valid = 1'b1; t.re = re; t.we = we; t.sz = sz; t.addr = addr;
    t.wdata = wdata; t.rdata = rdata; t.uns = uns; t.excp = excp;
    t.aok = aok; t.dok = dok; t.fmode = fmode; t.has_exp = has_exp; t.exp_ld = exp_ld;
    return t;
  endfunction

  // ---------------- monitor: pops the scoreboard on DUT output events ----------------
  initial begin
    req_t        r;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst) continue;
      if (dbus.data_req && dbus.data_addr_ok) begin
        if (req_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL req_unexpected: got acceptance addr=%0h required none", dbus.data_addr);
        end else begin
          r = req_q.pop_front();
          chk("req_wr",    32'(dbus.data_wr),    32'(r.wr));
          chk("req_addr",  dbus.data_addr,       r.addr);
          chk("req_size",  32'(dbus.data_size),  32'(r.sz));
          chk("req_wstrb", 32'(dbus.data_wstrb), 32'(r.wstrb));
          if (r.wr) chk("req_wdata", dbus.data_wdata, r.wdata);
        end
      end
      if (ld_valid && mm2_ready) begin
        if (ld_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ld_unexpected: got ld_data=%0h required no result", ld_data);
        end else begin
          e = ld_q.pop_front();
          chk("ld_data", ld_data, e);
        end
      end
    end
  end

  // ---------------- stimulus + memory model ----------------
  instr_t      cur;
  int          phase;       // 0 nothing to issue, 1 awaiting acceptance, 2 in flight, 3 done
  int          idx, ndir, since, cnt, cyc;
  bit          pend, owner_alive, flush_now, dok, acc, exp_stall, exp_req, pend_before;
  logic [31:0] pend_rd;

  task automatic advance();
    if (idx < prog.size()) begin
      cur = prog[idx];
      idx++;
    end else begin
      cur = mk(0, 0, SZ_W, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);
      cur.valid = 1'b0;
    end
    since = 0;
    if (eligible(cur)) begin
      phase = 1;
      req_q.push_back(model_req(cur));
    end else begin
      phase = 0;
    end
  endtask

  initial begin
    // directed cases
    prog.push_back(mk(1, 0, SZ_W, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
    prog.push_back(mk(1, 0, SZ_B, 32'h1003, 32'h0, 32'h80FF0000, 0, 0, 0, 1, 0, 1, 32'hFFFFFF80));
    prog.push_back(mk(1, 0, SZ_B, 32'h1003, 32'h0, 32'h80FF0000, 1, 0, 0, 0, 0, 1, 32'h00000080));
    prog.push_back(mk(0, 1, SZ_H, 32'h2002, 32'h1234ABCD, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0));
    prog.push_back(mk(1, 0, SZ_W, 32'h1004, 32'h0, 32'hCAFEF00D, 0, 0, 3, 0, 0, 1, 32'hCAFEF00D));
    prog.push_back(mk(1, 0, SZ_W, 32'h1008, 32'h0, 32'h11111111, 0, 0, 0, 2, 1, 0, 32'h0));
    prog.push_back(mk(1, 0, SZ_W, 32'h3000, 32'h0, 32'h22223333, 0, 0, 0, 0, 0, 1, 32'h22223333));
    prog.push_back(mk(1, 0, SZ_H, 32'h3002, 32'h0, 32'h87654321, 0, 0, 0, 1, 2, 0, 32'h0));
    prog.push_back(mk(1, 0, SZ_W, 32'h1010, 32'h0, 32'h44444444, 0, 1, 0, 0, 0, 0, 32'h0));
    prog.push_back(mk(1, 0, SZ_W, 32'h1002, 32'h0, 32'h55555555, 0, 0, 0, 0, 0, 0, 32'h0));
    prog.push_back(mk(1, 0, SZ_H, 32'h3002, 32'h0, 32'h8001ABCD, 0, 0, 1, 0, 0, 1, 32'hFFFF8001));
    ndir = prog.size();

    // random cases
    for (int k = 0; k < 300; k++) begin
      instr_t t;
      int     kind = int'($urandom_range(9));
      int     fm   = int'($urandom_range(9));
      t.valid   = ($urandom_range(9) != 0);
      t.re      = (kind < 5);
      t.we      = (kind >= 5 && kind < 9);
      t.excp    = ($urandom_range(11) == 0);
      t.uns     = 1'($urandom_range(1));
      t.sz      = 2'($urandom_range(3));
      t.addr    = $urandom;
      if ($urandom_range(7) != 0) t.addr = t.addr & ~(32'(nbytes(t.sz)) - 32'd1);
      t.wdata   = $urandom;
      t.rdata   = $urandom;
      t.aok     = int'($urandom_range(3));
      t.dok     = int'($urandom_range(3));
      t.fmode   = (fm < 7) ? 0 : (fm < 9) ? 1 : 2;
      if (t.fmode == 1 && t.dok == 0) t.dok = 1;
      t.has_exp = 1'b0;
      t.exp_ld  = 32'h0;
      prog.push_back(t);
    end

    rst = 1'b1;
    mm1_valid = 0; mm1_re = 0; mm1_we = 0; mm1_ld_unsigned = 0; mm1_excp = 0;
    mm1_access_sz = 2'd0; mm1_addr = 32'h0; mm1_wdata = 32'h0;
    flush = 0; mm2_ready = 0;
    dbus.data_addr_ok = 0; dbus.data_data_ok = 0; dbus.data_rdata = 32'h0;

    repeat (3) @(negedge clk);
    #3;
    chk("reset_ld_valid",  32'(ld_valid),      32'h0);
    chk("reset_ld_data",   ld_data,            32'h0);
    chk("reset_data_req",  32'(dbus.data_req), 32'h0);
    chk("reset_mm1_stall", 32'(mm1_stall),     32'h0);

    idx = 0; pend = 0; owner_alive = 0; cnt = 0; pend_rd = 32'h0; cyc = 0;
    cur = mk(0, 0, SZ_W, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);
    cur.valid = 1'b0; phase = 0; since = 0;

    @(negedge clk);
    rst = 1'b0;

    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        checks++; failures++;
        $display("FAIL timeout: got %0d of %0d instructions retired required all", idx, prog.size());
        break;
      end
      if (idx >= prog.size() && phase == 0 && !pend && !cur.valid) break;

      flush_now = (phase == 2) && ((cur.fmode == 1 && cnt > 0) || (cur.fmode == 2 && cnt == 0));
      dok       = pend && (cnt == 0);

      mm1_valid       = cur.valid;
      mm1_re          = cur.re;
      mm1_we          = cur.we;
      mm1_access_sz   = cur.sz;
      mm1_addr        = cur.addr;
      mm1_wdata       = cur.wdata;
      mm1_ld_unsigned = cur.uns;
      mm1_excp        = cur.excp;
      flush           = flush_now;
      mm2_ready       = (idx <= ndir) ? 1'b1 : ($urandom_range(3) != 0);
      dbus.data_addr_ok = (phase == 1) ? (since >= cur.aok) : 1'($urandom_range(1));
      dbus.data_data_ok = dok;
      dbus.data_rdata   = dok ? pend_rd : $urandom;

      #3;
      case (phase)
        0:       exp_stall = pend && mem_op(cur);
        3:       exp_stall = !mm2_ready;
        default: exp_stall = 1'b1;
      endcase
      exp_req = (phase == 1) && !pend;
      chk("data_req",  32'(dbus.data_req), 32'(exp_req));
      chk("mm1_stall", 32'(mm1_stall),     32'(exp_stall));
      chk("ld_valid",  32'(ld_valid),      32'(phase == 3 && !cur.we));

      acc         = dbus.data_req && dbus.data_addr_ok;
      pend_before = pend;

      if (dok) begin
        pend = 1'b0;
        if (owner_alive && !flush_now && phase == 2) begin
          phase = 3;
          if (!cur.we) ld_q.push_back(cur.has_exp ? cur.exp_ld : model_ld(cur, pend_rd));
        end
        owner_alive = 1'b0;
      end else if (pend) begin
        cnt--;
      end

      if (acc && !pend_before) begin
        pend        = 1'b1;
        owner_alive = (phase == 1);
        cnt         = (phase == 1) ? cur.dok : 0;
        pend_rd     = cur.rdata;
        if (phase == 1) phase = 2;
      end

      if (flush_now) owner_alive = 1'b0;

      if (flush_now || !exp_stall) advance();
      else since++;
    end

    repeat (2) @(negedge clk);
    chk("req_queue_drained", 32'(req_q.size()), 32'h0);
    chk("ld_queue_drained",  32'(ld_q.size()),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm1_dmem_if.md
Name: mm1_dmem_if

Overview:
MM1-stage data-memory front end and consumer of the EX/MM1 pipeline register's memory fields (re, we, access size, addr, wdata, flush_before-gated enables).
- Converts one held MM1 access into a request on the SRAM-like data bus (req/addr_ok, then data_ok).
- Aligns and extends load data.
- Stalls the EX/MM1 register until the access completes.
- Discards in-flight responses that belong to flushed instructions.

Parameters:
ALE_SUPPRESS, 1, when 1 a misaligned access (half with addr[0]=1, word with addr[1:0]!=0) is never issued to the bus.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
mm1_valid  in  1  MM1 holds a live instruction
mm1_re  in  1  load enable (already flush_before-gated upstream)
mm1_we  in  1  store enable (already flush_before-gated upstream)
mm1_access_sz  in  2  0 byte, 1 half, 2 word; 3 reserved, treated as word
mm1_addr  in  32  byte address
mm1_wdata  in  32  store data, LSB-aligned
mm1_ld_unsigned  in  1  zero-extend loads
mm1_excp  in  1  OR of MM1 exception flags (adef/sys/brk/ine/ale/ertn/interrupt)
flush  in  1  pipeline flush, same signal as the EX/MM1 register's flush
mm2_ready  in  1  MM1/MM2 register accepts this cycle
data_req  out  1  bus request
data_wr  out  1  1 store, 0 load
data_size  out  2  equals mm1_access_sz
data_addr  out  32  equals mm1_addr
data_wstrb  out  4  byte strobes
data_wdata  out  32  replicated store data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  response/write-complete
data_rdata  in  32  raw read word
mm1_stall  out  1  hold EX/MM1 register and upstream
ld_valid  out  1  ld_data valid for the MM1/MM2 register
ld_data  out  32  aligned, extended load result

Behaviour:
- Definition: access_en = mm1_valid & (mm1_re|mm1_we) & !mm1_excp & !flush & !(ALE_SUPPRESS & misaligned).
- At most one outstanding bus transaction.
- FSM states: IDLE, WAIT, DONE, CANCEL. Reset state is IDLE. Reset values: ld_data=0, ld_valid=0, data_req=0, mm1_stall=0.
- IDLE:
  - data_req = access_en (combinational); mm1_stall = access_en.
  - If data_req & data_addr_ok, go to WAIT. Otherwise stay; the inputs are held stable by the stall.
- WAIT:
  - data_req=0; mm1_stall=1.
  - On data_data_ok: load captures ld_data and sets ld_valid; store just completes. Next state DONE.
  - flush without data_data_ok, go to CANCEL.
  - flush with data_data_ok in the same cycle: the response is consumed and discarded, next state IDLE.
- DONE:
  - data_req=0; mm1_stall = !mm2_ready.
  - If mm2_ready or flush, clear ld_valid and go to IDLE.
  - The instruction is never reissued.
- CANCEL:
  - data_req=0; mm1_stall = mm1_valid & (mm1_re|mm1_we).
  - On data_data_ok, discard data and go to IDLE.
  - A new access issues only from IDLE, never in the cycle data_ok arrives in CANCEL.
- Minimum latency: addr_ok at cycle 0, data_ok at cycle 1, result visible in DONE at cycle 2. mm1_stall deasserts in DONE when mm2_ready=1.
- wstrb:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - loads: 4'b0000
- wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction: sh = data_rdata >> (8*addr[1:0]).
  - byte: ext(sh[7:0])
  - half: ext(sh[15:0])
  - word: data_rdata
  - ext = zero-extend if mm1_ld_unsigned, else sign-extend.
- A store with data_ok ends in DONE with ld_valid=0.
- Asynchronous rst in any state forces IDLE. A pending bus response is the memory model's responsibility after reset.

Decomposition:
- Shared defs package: access-size encodings (SZ_B=0, SZ_H=1, SZ_W=2) and FSM state encodings.
- One sub-module, mm1_ld_align: combinational strobe generation, wdata replication and load extraction/extension.
- FSM and ld_data register stay in mm1_dmem_if.

Test Plan:
- Word load, addr 0x1000, addr_ok same cycle, data_ok next cycle, rdata 0xDEADBEEF -> one req pulse; ld_data=0xDEADBEEF two cycles after req; mm1_stall low in DONE with mm2_ready=1.
- Signed byte load, addr 0x1003, rdata 0x80FF_0000 -> ld_data=0xFFFFFF80. Unsigned -> 0x00000080.
- Half store, addr 0x2002, wdata 0x1234ABCD -> data_wstrb=4'b1100, data_wdata=0xABCDABCD, data_wr=1, ld_valid stays 0.
- addr_ok held low 3 cycles -> data_req and mm1_stall high all 3 cycles with stable addr. Exactly one acceptance.
- Flush in WAIT, data_ok 2 cycles later, next load already presented -> no req until the CANCEL data_ok cycle has passed. Flushed data never appears on ld_data. Next load issues from IDLE.
- mm1_excp=1 or misaligned word addr 0x1002 -> data_req never asserts, mm1_stall=0.
